// File: rtl/rr_requester_if.sv
// rr_requester_if
//   Groups the producer side, arbiter lane and status signals of one
//   round-robin requester agent.
//   master : the requester agent (drives req, in_ready, issue/status outputs)
//   slave  : the environment (producer, arbiter lane, consumer/monitor)
//
//   in_valid/in_data/in_ready : producer push handshake
//   req/gnt                   : arbiter lane request/grant
//   out_valid/out_data        : issued word, one-cycle pulse
//   wait_cnt/starve/gnt_err   : grant-latency and protocol monitors
interface rr_requester_if #(
    parameter int DATA_W = 8,
    parameter int WAIT_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              req;
    logic              gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic              starve;
    logic              gnt_err;

    modport master (
        input  in_valid, in_data, gnt,
        output in_ready, req, out_valid, out_data, wait_cnt, starve, gnt_err
    );

    modport slave (
        output in_valid, in_data, gnt,
        input  in_ready, req, out_valid, out_data, wait_cnt, starve, gnt_err
    );
endinterface

// File: rtl/rr_requester.sv
// rr_requester
//   Requester-side agent for one lane of a 4-way round-robin arbiter.
//   Buffers producer words in a DEPTH-entry FIFO, requests the lane while
//   data is queued, issues one word per granted cycle, and monitors grant
//   latency (starve) and grants arriving without a request (gnt_err).
//
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rr_requester_if.master (producer push, req/gnt lane, issue, status)
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | FIFO empty, req low
//   REQ   | at least one word queued, req high
module rr_requester #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    rr_requester_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              starve_q,    starve_d;
    logic              gnt_err_q,   gnt_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic req;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // req comes from state only, so the arbiter's combinational gnt can
    // never loop back into it.
    assign req   = (state_q == S_REQ);
    assign push  = bus.in_valid && !full;
    // empty guard is redundant while in REQ but protects the pointers.
    assign pop   = req && bus.gnt && !empty;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        wait_cnt_d  = '0;
        starve_d    = starve_q;
        gnt_err_d   = gnt_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (push || !empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pop && (count_q == CNT_W'(1)) && !push) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (req && !bus.gnt) begin
            if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            // This edge takes the count past the largest legal wait.
            if (wait_cnt_q >= WAIT_W'(MAX_WAIT)) begin
                starve_d = 1'b1;
            end
        end

        if (bus.gnt && !req) begin
            gnt_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wait_cnt_q  <= '0;
            starve_q    <= 1'b0;
            gnt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.req       = req;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.wait_cnt  = wait_cnt_q;
    assign bus.starve    = starve_q;
    assign bus.gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_rr_requester.sv
module tb_rr_requester;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_requester_if #(.DATA_W(8), .WAIT_W(8)) bus ();

    rr_requester #(
        .DATA_W(8), .DEPTH(4), .WAIT_W(8), .MAX_WAIT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.gnt      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.gnt      = 1'b1;
        step();
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.gnt      = 1'b0;
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req actual=%b required=0", bus.req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid actual=%b required=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data actual=%h required=00", bus.out_data); end
        total++; if (bus.wait_cnt !== 8'd0) begin bad++; $display("FAIL rst_wait_cnt actual=%0d required=0", bus.wait_cnt); end
        total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL rst_starve actual=%b required=0", bus.starve); end
        total++; if (bus.gnt_err !== 1'b0) begin bad++; $display("FAIL rst_gnt_err actual=%b required=0", bus.gnt_err); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready actual=%b required=1", bus.in_ready); end
        step();
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_no_accept req actual=%b required=0", bus.req); end
    endtask

    task automatic test_single_word();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL single_req actual=%b required=1", bus.req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid actual=%b required=0", bus.out_valid); end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid actual=%b required=1", bus.out_valid); end
        total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL single_out_data actual=%h required=a5", bus.out_data); end
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL single_req_drop actual=%b required=0", bus.req); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse actual=%b required=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL single_hold actual=%h required=a5", bus.out_data); end
    endtask

    // words[31:24] is pushed first.
    task automatic test_fill_drain(input logic [31:0] words);
        logic [7:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = words[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d actual=%b required=1", i, bus.in_ready); end
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            step();
        end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full actual=%b required=0", bus.in_ready); end
        total++; if (bus.wait_cnt !== 8'd3) begin bad++; $display("FAIL fill_wait actual=%0d required=3", bus.wait_cnt); end
        // 0x55 is offered while full; the pop on the same edge must not let it in.
        bus.in_data = 8'h55;
        bus.gnt     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== w[i]) begin bad++; $display("FAIL drain_%0d actual=%b/%h required=1/%h", i, bus.out_valid, bus.out_data, w[i]); end
            total++; if (bus.req !== (i < 3)) begin bad++; $display("FAIL drain_req_%0d actual=%b required=%b", i, bus.req, (i < 3)); end
            if (i < 3) step();
        end
        bus.gnt = 1'b0;
        total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL fill_starve actual=%b required=0", bus.starve); end
        step();
        total++; if (bus.out_valid !== 1'b0 || bus.req !== 1'b0) begin bad++; $display("FAIL drain_end valid/req actual=%b/%b required=0/0", bus.out_valid, bus.req); end
        total++; if (bus.gnt_err !== 1'b0) begin bad++; $display("FAIL drain_gnt_err actual=%b required=0", bus.gnt_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic [7:0] got;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB1; exp_q.push_back(8'hB1); step();
        bus.in_data  = 8'hB2; exp_q.push_back(8'hB2); step();
        bus.gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'hC1 + 8'(i);
            exp_q.push_back(bus.in_data);
            step();
            got = exp_q.pop_front();
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== got) begin bad++; $display("FAIL pp_out_%0d actual=%b/%h required=1/%h", i, bus.out_valid, bus.out_data, got); end
            total++; if (bus.req !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL pp_req_ready_%0d actual=%b/%b required=1/1", i, bus.req, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            got = exp_q.pop_front();
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== got) begin bad++; $display("FAIL pp_tail_%0d actual=%b/%h required=1/%h", i, bus.out_valid, bus.out_data, got); end
        end
        bus.gnt = 1'b0;
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL pp_req_drop actual=%b required=0", bus.req); end
    endtask

    task automatic test_starvation();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.wait_cnt !== 8'd0) begin bad++; $display("FAIL starve_wait0 actual=%0d required=0", bus.wait_cnt); end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (bus.wait_cnt !== 8'(i)) begin bad++; $display("FAIL starve_wait_%0d actual=%0d required=%0d", i, bus.wait_cnt, i); end
            total++; if (bus.starve !== (i >= 4)) begin bad++; $display("FAIL starve_flag_%0d actual=%b required=%b", i, bus.starve, (i >= 4)); end
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin bad++; $display("FAIL starve_issue actual=%b/%h required=1/5a", bus.out_valid, bus.out_data); end
        total++; if (bus.wait_cnt !== 8'd0) begin bad++; $display("FAIL starve_wait_clr actual=%0d required=0", bus.wait_cnt); end
        total++; if (bus.starve !== 1'b1) begin bad++; $display("FAIL starve_sticky actual=%b required=1", bus.starve); end
        total++; if (bus.gnt_err !== 1'b0) begin bad++; $display("FAIL starve_gnt_err actual=%b required=0", bus.gnt_err); end
    endtask

    task automatic test_protocol_error();
        apply_reset();
        total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL perr_starve_rst actual=%b required=0", bus.starve); end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        total++; if (bus.gnt_err !== 1'b1) begin bad++; $display("FAIL perr_set actual=%b required=1", bus.gnt_err); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL perr_no_issue actual=%b required=0", bus.out_valid); end
        step();
        total++; if (bus.gnt_err !== 1'b1) begin bad++; $display("FAIL perr_sticky actual=%b required=1", bus.gnt_err); end
        total++; if (bus.req !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL perr_empty req/ready actual=%b/%b required=0/1", bus.req, bus.in_ready); end
        // Count must still be 0: one push then one grant empties the FIFO.
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; step();
        bus.in_valid = 1'b0; bus.gnt = 1'b1; step();
        bus.gnt = 1'b0;
        total++; if (bus.out_data !== 8'h3C || bus.req !== 1'b0) begin bad++; $display("FAIL perr_count data/req actual=%h/%b required=3c/0", bus.out_data, bus.req); end
        // Reset with words queued discards them.
        bus.in_valid = 1'b1; bus.in_data = 8'h77; step(); step();
        bus.in_valid = 1'b0;
        apply_reset();
        total++; if (bus.gnt_err !== 1'b0) begin bad++; $display("FAIL perr_rst_clr actual=%b required=0", bus.gnt_err); end
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL perr_rst_req actual=%b required=0", bus.req); end
        step();
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL perr_rst_discard actual=%b required=0", bus.req); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.gnt      = 1'b0;
        #1;
        test_reset();
        test_single_word();
        test_fill_drain(32'h11223344);
        test_fill_drain(32'h66778899);
        test_back_to_back();
        test_starvation();
        test_protocol_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_requester.md
Name: rr_requester

Overview:
- Requester-side agent for the 4-way round-robin arbiter: one instance sits on each of the arbiter's request/grant lanes.
- Buffers outgoing words from a local producer in a small FIFO and raises req while it has data.
- On each cycle where its grant is high, it issues exactly one word to the shared resource.
- Also monitors grant latency (starvation detection) and flags protocol errors (grant without request).

Parameters:
- DATA_W, 8, width of a buffered/issued word
- DEPTH, 4, FIFO entries; power of two, >=2
- WAIT_W, 8, width of wait-cycle counter
- MAX_WAIT, 3, largest legal number of consecutive req-high-without-gnt cycles (4-way round robin guarantees <=3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_data  input  DATA_W  producer word
- in_ready  output  1  FIFO can accept; word transferred when in_valid & in_ready at clk edge
- req  output  1  request to arbiter lane
- gnt  input  1  grant from arbiter lane (combinational on arbiter side)
- out_valid  output  1  one-cycle pulse: out_data is an issued word
- out_data  output  DATA_W  issued word
- wait_cnt  output  WAIT_W  consecutive cycles req high without gnt
- starve  output  1  sticky: wait exceeded MAX_WAIT
- gnt_err  output  1  sticky: gnt seen while req low

Behaviour:
- Reset values (sync rst, clk edge): FIFO empty (rd/wr pointers 0, count 0), state IDLE, req=0, out_valid=0, out_data=0, wait_cnt=0, starve=0, gnt_err=0. in_ready=1 after reset.
- Reset mid-operation discards all queued words; req is low in the cycle after the reset edge.
- Outputs are registered:
  - req is driven only from state, never from gnt, so there is no combinational loop through the arbiter.
  - in_ready = !full; it is also registered-derived and independent of gnt.
- Push: in_valid & in_ready at an edge writes in_data at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop (grant): req & gnt at an edge:
  - out_data <= FIFO head; out_valid <= 1 for one cycle; rd_ptr wraps modulo DEPTH.
  - Otherwise out_valid <= 0 and out_data holds its value.
- Simultaneous push and pop: count unchanged and both pointers advance.
- Push while full: not possible, because in_ready=0; a word offered with in_ready=0 is not accepted.
- FSM, two states:
  - IDLE (req=0) -> REQ when a push occurs or count > 0.
  - REQ (req=1) -> IDLE when a pop takes the last word and no push occurs in the same cycle; otherwise stay in REQ.
  - Latency: word pushed at edge N gives req=1 during cycle N+1. If gnt=1 in that cycle, out_valid=1 during cycle N+2.
- Back-to-back grants: with continuous gnt and k queued words, k consecutive out_valid pulses occur, in FIFO order.
- wait_cnt:
  - Increments (saturating at 2^WAIT_W-1) at each edge where req=1 & gnt=0.
  - Clears to 0 at an edge where gnt=1 or req=0.
- starve: set at the edge where wait_cnt would reach MAX_WAIT+1. Cleared only by rst.
- gnt_err: set at an edge where gnt=1 & req=0. Cleared only by rst. Such a grant causes no pop and no out_valid.
- Count width: log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, gnt=1 -> after release req=0, out_valid=0, wait_cnt=0, starve=0, gnt_err=0, in_ready=1, and no word accepted during reset.
- Single word: push 0xA5 at edge N, gnt=1 whenever req -> req=1 in cycle N+1; out_valid=1 with out_data=0xA5 in cycle N+2; req=0 in cycle N+2.
- Fill/drain with wrap:
  - Push 0x11,0x22,0x33,0x44 with gnt=0 -> in_ready=0 after the 4th push; 0x55 offered is not accepted.
  - Then gnt=1 continuously -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; req drops after the last.
  - Repeat a second fill to exercise pointer wrap.
- Simultaneous push/pop: FIFO holds 2 words, gnt=1 and in_valid=1 for 3 cycles -> count stays 2, req stays 1, and output order matches input order.
- Starvation: 1 word queued, gnt=0 for 5 cycles -> wait_cnt reads 1,2,3,4,5; starve=1 from the edge where wait_cnt becomes 4. Then gnt=1 -> word issued, wait_cnt=0, starve stays 1.
- Protocol error: FIFO empty, gnt=1 one cycle -> gnt_err=1 sticky, out_valid stays 0, count stays 0; rst clears gnt_err.
